// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out handshake bundle for byte_word_packer.
// PACKER_PARITY_EN adds out_parity (one even-parity bit per lane).
interface byte_word_packer_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_word;
  logic [2:0]  out_bytes;
  logic        out_valid;
  logic        out_ready;
`ifdef PACKER_PARITY_EN
  logic [3:0]  out_parity;
`endif

  modport master (
    output in_byte, in_valid, flush, out_ready,
    input  in_ready, out_word, out_bytes, out_valid
`ifdef PACKER_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_byte, in_valid, flush, out_ready,
    output in_ready, out_word, out_bytes, out_valid
`ifdef PACKER_PARITY_EN
    , output out_parity
`endif
  );
endinterface

// File: rtl/byte_word_packer.sv
// Packs bytes little-endian into 32-bit words behind a show-ahead FIFO.
// Optional macro PACKER_PARITY_EN stores per-lane parity with each word.
module byte_word_packer #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  byte_word_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   acc_data, acc_data_nxt, merged;
  logic [1:0]    acc_cnt, acc_cnt_nxt;
  logic [2:0]    sum_cnt;
  logic          take, fl, push, pop;
  logic [2:0]    push_bytes;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ;
  logic          full, empty;

  logic [31:0]   word_mem  [DEPTH];
  logic [2:0]    bytes_mem [DEPTH];
`ifdef PACKER_PARITY_EN
  logic [3:0]    par_mem   [DEPTH];
  logic [3:0]    push_par;
`endif

  assign full  = (occ == CW'(DEPTH));
  assign empty = (occ == '0);

  // Outputs are forced quiet during reset, before the state is cleared.
  assign bus.in_ready  = !rst && !full;
  assign bus.out_valid = !rst && !empty;
  assign bus.out_word  = bus.out_valid ? word_mem[rd_ptr]  : '0;
  assign bus.out_bytes = bus.out_valid ? bytes_mem[rd_ptr] : '0;
`ifdef PACKER_PARITY_EN
  assign bus.out_parity = bus.out_valid ? par_mem[rd_ptr] : '0;
`endif

  assign take = bus.in_valid && bus.in_ready;
  assign fl   = bus.flush && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    merged = acc_data;
    if (take) merged[{acc_cnt, 3'b000} +: 8] = bus.in_byte;
    sum_cnt      = {1'b0, acc_cnt} + {2'b00, take};
    push         = 1'b0;
    push_bytes   = sum_cnt;
    acc_data_nxt = merged;
    acc_cnt_nxt  = sum_cnt[1:0];
    if (sum_cnt[2]) begin
      push         = 1'b1;
      acc_data_nxt = '0;
      acc_cnt_nxt  = '0;
    end else if (fl && sum_cnt != 3'd0) begin
      push         = 1'b1;
      acc_data_nxt = '0;
      acc_cnt_nxt  = '0;
    end
  end

`ifdef PACKER_PARITY_EN
  // Unfilled lanes are always zero, so their parity comes out 0.
  always_comb begin
    push_par = '0;
    for (int k = 0; k < 4; k++) push_par[k] = ^merged[8*k +: 8];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_data <= '0;
      acc_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else begin
      acc_data <= acc_data_nxt;
      acc_cnt  <= acc_cnt_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr]  <= merged;
      bytes_mem[wr_ptr] <= push_bytes;
`ifdef PACKER_PARITY_EN
      par_mem[wr_ptr]   <= push_par;
`endif
    end
  end
endmodule
